// File: rtl/dp_ram_be.sv
`default_nettype none
// ============================================================================
//  Module   : dp_ram_be
//  Purpose  : Single-clock true dual-port RAM with per-byte write enables,
//             selectable same-port read-during-write, write/write collision
//             arbitration (port A wins) and a hardware clear engine.
//  Revision : 1.0  initial release
// ============================================================================
module dp_ram_be #(
    parameter int                     ADDR_BITS   = 8,
    parameter int                     DATA_BITS   = 32,
    parameter int                     BYTE_BITS   = 8,
    parameter int                     RDW_MODE    = 0,
    parameter logic [DATA_BITS-1:0]   CLEAR_VALUE = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr_req,
    output logic                           busy,
    input  logic [ADDR_BITS-1:0]           addr_a,
    input  logic [DATA_BITS-1:0]           din_a,
    input  logic [DATA_BITS/BYTE_BITS-1:0] be_a,
    input  logic                           wr_en_a,
    input  logic                           rd_en_a,
    output logic [DATA_BITS-1:0]           dout_a,
    output logic                           rvalid_a,
    input  logic [ADDR_BITS-1:0]           addr_b,
    input  logic [DATA_BITS-1:0]           din_b,
    input  logic [DATA_BITS/BYTE_BITS-1:0] be_b,
    input  logic                           wr_en_b,
    input  logic                           rd_en_b,
    output logic [DATA_BITS-1:0]           dout_b,
    output logic                           rvalid_b,
    output logic                           collision
);

    localparam int c_NB    = DATA_BITS / BYTE_BITS;
    localparam int c_DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ADDR_BITS-1:0]   r_ptr;
    logic [ADDR_BITS-1:0]   w_ptr_nxt;
    logic                   w_clear_we;
    logic                   w_ok;
    logic                   w_collide;
    logic [DATA_BITS-1:0]   w_old_a;
    logic [DATA_BITS-1:0]   w_old_b;
    logic [DATA_BITS-1:0]   w_rdata_a;
    logic [DATA_BITS-1:0]   w_rdata_b;

    logic [DATA_BITS-1:0]   r_mem [c_DEPTH];

    // Port accesses are honoured only in IDLE and not on the edge that starts a clear.
    assign w_ok   = (r_state == ST_IDLE) && !clr_req;
    assign busy   = (r_state == ST_CLEAR);
    assign w_old_a = r_mem[addr_a];
    assign w_old_b = r_mem[addr_b];

    // Overlapping lanes on a same-address double write; never flagged while busy.
    assign w_collide = w_ok && wr_en_a && wr_en_b && (addr_a == addr_b) && (|(be_a & be_b));

    // Same-port read-during-write: new-data mode merges the own port's enabled lanes.
    generate
        if (RDW_MODE == 1) begin : g_rdw_new
            for (genvar i = 0; i < c_NB; i++) begin : g_lane
                assign w_rdata_a[i*BYTE_BITS +: BYTE_BITS] = (wr_en_a && be_a[i]) ?
                    din_a[i*BYTE_BITS +: BYTE_BITS] : w_old_a[i*BYTE_BITS +: BYTE_BITS];
                assign w_rdata_b[i*BYTE_BITS +: BYTE_BITS] = (wr_en_b && be_b[i]) ?
                    din_b[i*BYTE_BITS +: BYTE_BITS] : w_old_b[i*BYTE_BITS +: BYTE_BITS];
            end
        end else begin : g_rdw_old
            assign w_rdata_a = w_old_a;
            assign w_rdata_b = w_old_b;
        end
    endgenerate

    // Clear FSM state and sweep pointer; reset restarts the sweep from address 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Next-state logic: sweep once through the array, no wrap; clr_req only heard in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_clear_we  = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clear_we = 1'b1;
                if (r_ptr == {ADDR_BITS{1'b1}}) begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = '0;
                end else begin
                    w_ptr_nxt = r_ptr + 1'b1;
                end
            end
            default: begin
                if (clr_req) begin
                    w_state_nxt = ST_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
        endcase
    end

    // Array writes: clear engine, else port B lanes then port A lanes so A wins overlaps.
    always_ff @(posedge clk) begin
        if (w_clear_we) begin
            r_mem[r_ptr] <= CLEAR_VALUE;
        end else if (w_ok) begin
            for (int i = 0; i < c_NB; i++) begin
                if (wr_en_b && be_b[i])
                    r_mem[addr_b][i*BYTE_BITS +: BYTE_BITS] <= din_b[i*BYTE_BITS +: BYTE_BITS];
                if (wr_en_a && be_a[i])
                    r_mem[addr_a][i*BYTE_BITS +: BYTE_BITS] <= din_a[i*BYTE_BITS +: BYTE_BITS];
            end
        end
    end

    // Read data, valid flags and collision flag; dout holds when no read is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_a    <= '0;
            dout_b    <= '0;
            rvalid_a  <= 1'b0;
            rvalid_b  <= 1'b0;
            collision <= 1'b0;
        end else begin
            rvalid_a  <= w_ok && rd_en_a;
            rvalid_b  <= w_ok && rd_en_b;
            collision <= w_collide;
            if (w_ok && rd_en_a)
                dout_a <= w_rdata_a;
            if (w_ok && rd_en_b)
                dout_b <= w_rdata_b;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dp_ram_be.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dp_ram_be
//  Purpose  : Directed self-checking bench for dp_ram_be (16-word array),
//             one instance per read-during-write mode on shared stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dp_ram_be;

    localparam int c_AB = 4;
    localparam int c_DB = 32;
    localparam int c_NB = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            clr_req;
    logic [c_AB-1:0] addr_a, addr_b;
    logic [c_DB-1:0] din_a, din_b;
    logic [c_NB-1:0] be_a, be_b;
    logic            wr_en_a, wr_en_b, rd_en_a, rd_en_b;

    logic            busy0, busy1;
    logic [c_DB-1:0] dout_a0, dout_b0, dout_a1, dout_b1;
    logic            rvalid_a0, rvalid_b0, rvalid_a1, rvalid_b1;
    logic            coll0, coll1;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dp_ram_be #(.ADDR_BITS(c_AB), .DATA_BITS(c_DB), .BYTE_BITS(8), .RDW_MODE(0),
                .CLEAR_VALUE(32'h0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy0),
        .addr_a(addr_a), .din_a(din_a), .be_a(be_a), .wr_en_a(wr_en_a), .rd_en_a(rd_en_a),
        .dout_a(dout_a0), .rvalid_a(rvalid_a0),
        .addr_b(addr_b), .din_b(din_b), .be_b(be_b), .wr_en_b(wr_en_b), .rd_en_b(rd_en_b),
        .dout_b(dout_b0), .rvalid_b(rvalid_b0), .collision(coll0));

    dp_ram_be #(.ADDR_BITS(c_AB), .DATA_BITS(c_DB), .BYTE_BITS(8), .RDW_MODE(1),
                .CLEAR_VALUE(32'h0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy1),
        .addr_a(addr_a), .din_a(din_a), .be_a(be_a), .wr_en_a(wr_en_a), .rd_en_a(rd_en_a),
        .dout_a(dout_a1), .rvalid_a(rvalid_a1),
        .addr_b(addr_b), .din_b(din_b), .be_b(be_b), .wr_en_b(wr_en_b), .rd_en_b(rd_en_b),
        .dout_b(dout_b1), .rvalid_b(rvalid_b1), .collision(coll1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clr_req = 1'b0;
        wr_en_a = 1'b0; wr_en_b = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0;
        be_a = '0; be_b = '0; din_a = '0; din_b = '0; addr_a = '0; addr_b = '0;
    endtask

    // Count a full clear: busy must hold for 15 sampled cycles and drop after the 16th.
    task automatic expect_full_clear(input string tag);
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 15) check({tag, "_busy_c15"}, {31'd0, busy0}, 32'd1);
            if (i == 16) check({tag, "_busy_c16"}, {31'd0, busy0}, 32'd0);
        end
    endtask

    task automatic read_a(input logic [3:0] a);
        addr_a = a; rd_en_a = 1'b1; wr_en_a = 1'b0;
        tick();
        rd_en_a = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;

        // ---- 1: reset state and clear after release ----
        #12;
        check("rst_busy",   {31'd0, busy0},     32'd1);
        check("rst_dout_a", dout_a0,            32'd0);
        check("rst_rvalid", {31'd0, rvalid_a0}, 32'd0);
        check("rst_coll",   {31'd0, coll0},     32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        expect_full_clear("init");
        for (int a = 0; a < 16; a++) begin
            read_a(4'(a));
            check($sformatf("init_rd%0d", a), dout_a0, 32'h0);
            check($sformatf("init_rv%0d", a), {31'd0, rvalid_a0}, 32'd1);
        end
        tick();
        check("init_rv_drop", {31'd0, rvalid_a0}, 32'd0);

        // ---- 2: byte-lane partial write, read on B ----
        addr_a = 4'd3; din_a = 32'hDEADBEEF; be_a = 4'b1111; wr_en_a = 1'b1;
        tick();
        din_a = 32'h00000011; be_a = 4'b0001;
        tick();
        wr_en_a = 1'b0; addr_b = 4'd3; rd_en_b = 1'b1;
        tick();
        rd_en_b = 1'b0;
        check("be_dout_b",   dout_b0, 32'hDEADBE11);
        check("be_rvalid_b", {31'd0, rvalid_b0}, 32'd1);

        // ---- 3: read-during-write, old vs new data ----
        addr_a = 4'd5; din_a = 32'hAAAAAAAA; be_a = 4'b1111; wr_en_a = 1'b1;
        tick();
        din_a = 32'h55555555; rd_en_a = 1'b1;
        tick();
        wr_en_a = 1'b0;
        check("rdw_mode0", dout_a0, 32'hAAAAAAAA);
        check("rdw_mode1", dout_a1, 32'h55555555);
        tick();
        rd_en_a = 1'b0;
        check("rdw_after0", dout_a0, 32'h55555555);
        check("rdw_after1", dout_a1, 32'h55555555);

        // ---- 4: write/write collision arbitration ----
        addr_a = 4'd7; din_a = 32'h11111111; be_a = 4'b0011; wr_en_a = 1'b1;
        addr_b = 4'd7; din_b = 32'h22222222; be_b = 4'b0110; wr_en_b = 1'b1;
        tick();
        wr_en_a = 1'b0; wr_en_b = 1'b0;
        check("coll_set", {31'd0, coll0}, 32'd1);
        read_a(4'd7);
        check("coll_clr",  {31'd0, coll0}, 32'd0);
        check("coll_word", dout_a0, 32'h00221111);
        be_b = 4'b1100; wr_en_a = 1'b1; wr_en_b = 1'b1;
        tick();
        wr_en_a = 1'b0; wr_en_b = 1'b0;
        check("nocoll", {31'd0, coll0}, 32'd0);
        read_a(4'd7);
        check("nocoll_word", dout_a0, 32'h22221111);

        // ---- 5: clear request mid-traffic ----
        addr_b = 4'd9; din_b = 32'h12345678; be_b = 4'b1111; wr_en_b = 1'b1;
        tick();
        wr_en_b = 1'b0;
        clr_req = 1'b1; addr_a = 4'd10; din_a = 32'hCAFEF00D; be_a = 4'b1111; wr_en_a = 1'b1;
        tick();
        clr_req = 1'b0; wr_en_a = 1'b0;
        check("clr_busy", {31'd0, busy0}, 32'd1);
        for (int i = 1; i <= 16; i++) begin
            if (i == 2) begin addr_a = 4'd9; rd_en_a = 1'b1; end
            if (i == 5) clr_req = 1'b1;
            if (i == 14) begin
                addr_b = 4'd0; din_b = 32'hFFFFFFFF; be_b = 4'b1111; wr_en_b = 1'b1;
                addr_a = 4'd0; din_a = 32'hEEEEEEEE; be_a = 4'b1111; wr_en_a = 1'b1;
            end
            tick();
            clr_req = 1'b0; rd_en_a = 1'b0; wr_en_a = 1'b0; wr_en_b = 1'b0;
            if (i == 2) begin
                check("clr_rvalid", {31'd0, rvalid_a0}, 32'd0);
                check("clr_dhold",  dout_a0, 32'h22221111);
            end
            if (i == 14) check("clr_nocoll", {31'd0, coll0}, 32'd0);
            if (i == 15) check("clr_busy_c15", {31'd0, busy0}, 32'd1);
            if (i == 16) check("clr_busy_c16", {31'd0, busy0}, 32'd0);
        end
        for (int a = 0; a < 16; a++) begin
            read_a(4'(a));
            check($sformatf("clr_rd%0d", a), dout_a0, 32'h0);
        end

        // ---- 6: reset halfway through a clear ----
        addr_a = 4'd4; din_a = 32'hCAFEF00D; be_a = 4'b1111; wr_en_a = 1'b1;
        tick();
        wr_en_a = 1'b0;
        read_a(4'd4);
        check("rst6_pre", dout_a0, 32'hCAFEF00D);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst6_busy", {31'd0, busy0}, 32'd1);
        check("rst6_dout", dout_a0, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        expect_full_clear("rst6");
        read_a(4'd4);
        check("rst6_word", dout_a0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
